// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - request/result bundle for the bit-serial adder/subtractor
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract, one full-adder slice reused over WIDTH cycles
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_bit;

  assign s_bit = opa[0] ^ opb[0] ^ carry;
  assign c_bit = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            opa      <= bus.a;
            opb      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= {s_bit, res[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB here; c_bit is the carry out.
            bus.sum  <= {s_bit, res[WIDTH-1:1]};
            bus.cout <= c_bit;
            bus.ovf  <= carry ^ c_bit;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and randomized checks of serial_addsub at WIDTH 8, 4 and 16
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  i8  ();
  serial_addsub_if #(.WIDTH(4))  i4  ();
  serial_addsub_if #(.WIDTH(16)) i16 ();

  serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_addsub #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
  serial_addsub #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum, ovf} from plain integer arithmetic.
  function automatic logic [63:0] model(input int w, input longint a, input longint b, input bit s);
    longint u, sa, sb, r, half, full;
    logic   ov;
    full = longint'(64'sd1) <<< w;
    half = full / 2;
    u  = s ? a + (full - b) : a + b;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    r  = s ? sa - sb : sa + sb;
    ov = (r < -half) || (r >= half);
    return (64'((u / full) % 2) << (w + 1)) | (64'(u % full) << 1) | 64'(ov);
  endfunction

  task automatic wait_done8(input string tag);
    int n = 0;
    while (!i8.done && n < 40) begin @(negedge clk); n++; end
    check(tag, 64'(n < 40), 64'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, output logic [9:0] r);
    i8.a = a; i8.b = b; i8.sub = s; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    wait_done8("run8_timeout");
    r = {i8.cout, i8.sum, i8.ovf};
    @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, output logic [5:0] r);
    int n = 0;
    i4.a = a; i4.b = b; i4.sub = s; i4.start = 1'b1;
    @(negedge clk);
    i4.start = 1'b0;
    while (!i4.done && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("run4_timeout", 64'(n), 64'd0);
    r = {i4.cout, i4.sum, i4.ovf};
    @(negedge clk);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, output logic [17:0] r);
    int n = 0;
    i16.a = a; i16.b = b; i16.sub = s; i16.start = 1'b1;
    @(negedge clk);
    i16.start = 1'b0;
    while (!i16.done && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) check("run16_timeout", 64'(n), 64'd0);
    r = {i16.cout, i16.sum, i16.ovf};
    @(negedge clk);
  endtask

  initial begin
    logic [9:0]  r8;
    logic [5:0]  r4;
    logic [17:0] r16;
    int          errs4;
    int          errs16;
    {i8.start, i8.sub, i8.a, i8.b}    = '0;
    {i4.start, i4.sub, i4.a, i4.b}    = '0;
    {i16.start, i16.sub, i16.a, i16.b} = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x00 + 0x00 with exact cycle timing
    i8.a = 8'h00; i8.b = 8'h00; i8.sub = 1'b0; i8.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      i8.start = 1'b0;
      check($sformatf("busy_run_c%0d", i), 64'({i8.busy, i8.done}), 64'b10);
    end
    @(negedge clk);
    check("done_at_8", 64'({i8.busy, i8.done}), 64'b01);
    check("add_0_0", 64'({i8.cout, i8.sum, i8.ovf}), model(8, 0, 0, 0));
    @(negedge clk);
    check("done_one_cycle", 64'(i8.done), 64'd0);

    run8(8'hFF, 8'h01, 1'b0, r8); check("add_ff_01", 64'(r8), {54'd0, 1'b1, 8'h00, 1'b0});
    run8(8'h7F, 8'h01, 1'b0, r8); check("add_7f_01", 64'(r8), {54'd0, 1'b0, 8'h80, 1'b1});
    run8(8'h05, 8'h07, 1'b1, r8); check("sub_05_07", 64'(r8), {54'd0, 1'b0, 8'hFE, 1'b0});
    run8(8'h80, 8'h01, 1'b1, r8); check("sub_80_01", 64'(r8), {54'd0, 1'b1, 8'h7F, 1'b1});
    run8(8'h33, 8'h33, 1'b1, r8); check("sub_33_33", 64'(r8), {54'd0, 1'b1, 8'h00, 1'b0});

    // start held high; a changed mid-run must not disturb the result
    i8.a = 8'h10; i8.b = 8'h20; i8.sub = 1'b0; i8.start = 1'b1;
    repeat (3) @(negedge clk);
    i8.a = 8'hAA;
    wait_done8("hold_timeout1");
    check("hold_first_sum", 64'(i8.sum), 64'h30);
    @(negedge clk);
    check("hold_ignored_in_done", 64'(i8.busy), 64'd0);
    @(negedge clk);
    check("hold_accept_after_idle", 64'(i8.busy), 64'd1);
    i8.start = 1'b0;
    wait_done8("hold_timeout2");
    check("hold_second_sum", 64'({i8.cout, i8.sum, i8.ovf}), model(8, 'hAA, 'h20, 0));
    @(negedge clk);

    // mid-operation reset
    run8(8'h12, 8'h34, 1'b0, r8); check("add_12_34", 64'(r8[8:1]), 64'h46);
    i8.a = 8'h01; i8.b = 8'h01; i8.sub = 1'b0; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_clears", 64'({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h02, 8'h03, 1'b0, r8); check("after_reset_02_03", 64'(r8), model(8, 2, 3, 0));

    // WIDTH=4 exhaustive
    errs4 = fails;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          run4(4'(a), 4'(b), 1'(s), r4);
          check($sformatf("w4_s%0d_a%0h_b%0h", s, a, b), 64'(r4), model(4, a, b, 1'(s)));
        end
    errs4 = fails - errs4;

    // WIDTH=16 random
    errs16 = fails;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      run16(ra, rb, rs, r16);
      check($sformatf("w16_%0d", i), 64'(r16), model(16, longint'(ra), longint'(rb), rs));
    end
    errs16 = fails - errs16;
    check("w4_and_w16_clean", 64'(errs4 + errs16), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
